updown_counter: RTL

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 98 +++++++++
 1 files changed

// File: rtl/updown_counter.sv
// Prescaled up/down counter with wrap or saturate at a programmable upper limit.
// Tick, rollover and a sticky saturation flag report what each step did.
module updown_counter #(
    parameter int N = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dir,
    input  logic         wrap,
    input  logic [N-1:0] max,
    input  logic [P-1:0] prescale,
    output logic [N-1:0] count,
    output logic         at_max,
    output logic         at_min,
    output logic         tick,
    output logic         rollover,
    output logic         sat_flag
);

    logic [P-1:0] pcnt;
    logic         step;
    logic [N-1:0] step_val;
    logic         step_roll;
    logic         step_sat;

    // >= so that lowering prescale below pcnt forces an immediate step
    assign step   = pcnt >= prescale;
    assign at_max = count >= max;
    assign at_min = count == '0;

    always_comb begin
        step_val  = count;
        step_roll = 1'b0;
        step_sat  = 1'b0;
        if (dir) begin
            if (count < max) begin
                step_val = count + 1'b1;
            end else if (wrap) begin
                step_val  = '0;
                step_roll = 1'b1;
            end else begin
                step_val = max;
                step_sat = 1'b1;
            end
        end else begin
            if (count > max) begin
                step_val = max;
            end else if (count != '0) begin
                step_val = count - 1'b1;
            end else if (wrap) begin
                step_val  = max;
                step_roll = 1'b1;
            end else begin
                step_val = '0;
                step_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count    <= '0;
            pcnt     <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
            sat_flag <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            pcnt     <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
            sat_flag <= 1'b0;
        end else if (load) begin
            count    <= (load_val <= max) ? load_val : max;
            pcnt     <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
        end else if (enable && step) begin
            count    <= step_val;
            pcnt     <= '0;
            tick     <= 1'b1;
            rollover <= step_roll;
            sat_flag <= sat_flag | step_sat;
        end else begin
            if (enable) begin
                pcnt <= pcnt + 1'b1;
            end
            tick     <= 1'b0;
            rollover <= 1'b0;
        end
    end

endmodule
